fifo_wr_arbiter: RTL

//   Shares the write port of the asynchronous FIFO between NUM_REQ requesters in the write-clock domain.

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the write port of an asynchronous FIFO between NUM_REQ requesters
//   that all live in the FIFO write-clock domain. Arbitration is round-robin
//   with burst locking: once a requester owns the port it keeps it for up to
//   MAX_BURST accepted words, or until it drops its request. The FIFO full
//   flag throttles writes without ending the burst. One idle cycle always
//   separates two bursts.
//
// Parameters:
//   NUM_REQ     number of requesters (2..16)
//   Data_width  FIFO word width
//   MAX_BURST   maximum words per grant (1..256)
//
// Ports:
//   clk        in   write-domain clock (same net as the FIFO write clock)
//   rst        in   asynchronous reset, active-low (0 = reset)
//   req        in   per-requester valid, held with its data until accepted
//   req_data   in   requester i data on bits [i*Data_width +: Data_width]
//   fifo_full  in   FIFO full flag, write domain
//   gnt        out  one-hot ready to the current owner; 0 when idle or full
//   Wr_en      out  FIFO write strobe (a word moves when req[i] && gnt[i])
//   Wr_data    out  FIFO write data (owner's word when Wr_en, else 0)
//   busy       out  1 while a burst is owned
//   cur_id     out  index of the current or last owner
//   wr_count   out  total accepted writes, 16-bit wrapping
//                   (only present when FIFO_ARB_WRCNT_EN is defined)
//
// Configuration:
//   FIFO_ARB_WRCNT_EN  when defined, adds the wr_count output and its counter.
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int Data_width = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*Data_width-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          Wr_en,
    output logic [Data_width-1:0]         Wr_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id
`ifdef FIFO_ARB_WRCNT_EN
    ,
    output logic [15:0]                   wr_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    // A one-word burst still needs a 1-bit counter to keep widths legal.
    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]      state_reg,      state_next;
    logic [ID_W-1:0] owner_reg,      owner_next;
    logic [ID_W-1:0] last_owner_reg, last_owner_next;
    logic [BC_W-1:0] beat_cnt_reg,   beat_cnt_next;

    logic                  in_burst;
    logic                  owner_req;
    logic                  pick_valid;
    logic [ID_W-1:0]       pick_id;
    int                    scan_idx;
    logic [Data_width-1:0] req_word [NUM_REQ];

    assign in_burst  = (state_reg == BURST);
    assign owner_req = req[owner_reg];

    // Per-requester data slices and grant lines.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi] = req_data[gi*Data_width +: Data_width];
            assign gnt[gi]      = in_burst && (owner_reg == ID_W'(gi)) && !fifo_full;
        end
    endgenerate

    assign Wr_en   = |(req & gnt);
    assign Wr_data = Wr_en ? req_word[owner_reg] : '0;
    assign busy    = in_burst;
    assign cur_id  = owner_reg;

    // Round-robin pick: scan last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ).
    // The loop runs from the farthest offset to the nearest so that the
    // nearest requesting index overwrites any earlier hit.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = int'(last_owner_reg) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        if (state_reg == IDLE) begin
            if (pick_valid) begin
                owner_next    = pick_id;
                beat_cnt_next = '0;
                state_next    = BURST;
            end
        end else begin
            if (!owner_req) begin
                // Owner withdrew: release the port without a write.
                state_next      = IDLE;
                last_owner_next = owner_reg;
            end else if (!fifo_full) begin
                // A word is accepted this cycle.
                if (beat_cnt_reg == LAST_BEAT) begin
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            // fifo_full with req held: hold everything and wait.
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= LAST_ID;   // next scan starts at requester 0
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

`ifdef FIFO_ARB_WRCNT_EN
    logic [15:0] wr_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_reg <= '0;
        end else if (Wr_en) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign wr_count = wr_count_reg;
`endif

endmodule
